// File: rtl/config_source_arbiter_pkg.sv
// Shared types and constants for the configuration source arbiter.
// Optional build macro used by the arbiter: CFG_ARB_TIMEOUT_EN.
package cfg_arb_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int COUNT_WIDTH_DEF = 16;

    // Source indices; the value doubles as the round-robin pointer encoding.
    localparam int SRC_UART = 0;
    localparam int SRC_HOST = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        OWN     = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    // One-hot grant vector for a source index.
    function automatic logic [1:0] src_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/config_source_arbiter_if.sv
// Word handshake between one bitstream loader and the arbiter.
// The loader is the master; the arbiter answers with ready.
interface config_source_arbiter_if #(
    parameter int DataWidth = 32
);
    logic [DataWidth-1:0] data;
    logic                 valid;
    logic                 active;
    logic                 ready;

    modport master (output data, output valid, output active, input ready);
    modport slave  (input data, input valid, input active, output ready);
endinterface

// File: rtl/config_source_arbiter_timeout.sv
// Idle timer for the arbiter: counts down OWN cycles without a transfer and
// signals the cycle that would reach TimeoutCycles. Only present when
// CFG_ARB_TIMEOUT_EN is defined.
`ifdef CFG_ARB_TIMEOUT_EN
module cfg_arb_timeout #(
    parameter int TimeoutCycles = 1048576
) (
    input  logic CLK,
    input  logic resetn,
    input  logic load_i,
    input  logic dec_i,
    output logic expire_o
);
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q;

    // Reload on every transfer / session start, count down on idle OWN cycles.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= CntW'(TimeoutCycles);
        end else if (load_i) begin
            cnt_q <= CntW'(TimeoutCycles);
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    // Terminal count: this idle cycle is the TimeoutCycles-th one.
    assign expire_o = dec_i && (cnt_q == CntW'(1));
endmodule
`endif

// File: rtl/config_source_arbiter.sv
// Shares the fabric configuration write port between the UART loader (src0)
// and the host loader (src1), one source per session, round-robin on conflict.
// Optional build macro: CFG_ARB_TIMEOUT_EN (forced release after an idle OWN period).
//
// state   | meaning
// IDLE    | no owner; arbitrate among active sources
// SYNC    | owner granted; FSM_Reset pulse, word counter cleared, no transfers
// OWN     | owner's words forwarded; leaves on active fall (or idle timeout)
// RELEASE | one dead cycle; round-robin pointer moved to the other source
module config_source_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int DataWidth     = DATA_WIDTH_DEF,
    parameter int CountWidth    = COUNT_WIDTH_DEF,
    parameter int TimeoutCycles = 1048576
) (
    input  logic                  CLK,
    input  logic                  resetn,
    config_source_arbiter_if.slave src0,
    config_source_arbiter_if.slave src1,
    output logic [DataWidth-1:0]  WriteData,
    output logic                  WriteStrobe,
    output logic                  FSM_Reset,
    output logic                  ComActive,
    output logic [1:0]            Grant,
    output logic [CountWidth-1:0] WordCount,
    output logic                  TimeoutFlag
);
    arb_state_e            state_q;
    logic [1:0]            grant_q;
    logic                  rr_q;
    logic [DataWidth-1:0]  wdata_q;
    logic                  wstrobe_q;
    logic                  fsm_reset_q;
    logic                  com_active_q;
    logic [CountWidth-1:0] wcount_q;
    logic                  timeout_q;

    logic                  in_own;
    logic                  xfer;
    logic                  own_active;
    logic                  forced_rel;
    logic [DataWidth-1:0]  xfer_data;
    logic [1:0]            pick;

    assign in_own     = (state_q == OWN);
    assign src0.ready = in_own && grant_q[SRC_UART] && src0.valid;
    assign src1.ready = in_own && grant_q[SRC_HOST] && src1.valid;

    // Select the owner's signals and decide who would win arbitration now.
    always_comb begin
        xfer       = src0.ready || src1.ready;
        xfer_data  = grant_q[SRC_HOST] ? src1.data : src0.data;
        own_active = grant_q[SRC_HOST] ? src1.active : src0.active;
        pick       = 2'b00;
        if (src0.active && src1.active) begin
            pick = src_onehot(rr_q);
        end else if (src0.active) begin
            pick = src_onehot(1'b0);
        end else if (src1.active) begin
            pick = src_onehot(1'b1);
        end
    end

`ifdef CFG_ARB_TIMEOUT_EN
    logic idle_expire;

    cfg_arb_timeout #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .CLK     (CLK),
        .resetn  (resetn),
        .load_i  ((state_q == SYNC) || xfer),
        .dec_i   (in_own && !xfer),
        .expire_o(idle_expire)
    );

    // A timeout only counts as forced when the owner still claims the port.
    assign forced_rel = idle_expire && own_active;
`else
    assign forced_rel = 1'b0;
`endif

    // Session FSM with registered outputs.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            rr_q         <= 1'b0;
            wdata_q      <= '0;
            wstrobe_q    <= 1'b0;
            fsm_reset_q  <= 1'b0;
            com_active_q <= 1'b0;
            wcount_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            wstrobe_q   <= 1'b0;
            fsm_reset_q <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick != 2'b00) begin
                        grant_q      <= pick;
                        com_active_q <= 1'b1;
                        fsm_reset_q  <= 1'b1;
                        wcount_q     <= '0;
                        state_q      <= SYNC;
                    end
                end
                SYNC: begin
                    state_q <= OWN;
                end
                OWN: begin
                    if (xfer) begin
                        wdata_q   <= xfer_data;
                        wstrobe_q <= 1'b1;
                        if (wcount_q != '1) begin
                            wcount_q <= wcount_q + CountWidth'(1);
                        end
                    end
                    if (!own_active || forced_rel) begin
                        rr_q         <= ~grant_q[SRC_HOST];
                        grant_q      <= 2'b00;
                        com_active_q <= 1'b0;
                        timeout_q    <= forced_rel;
                        state_q      <= RELEASE;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign WriteData   = wdata_q;
    assign WriteStrobe = wstrobe_q;
    assign FSM_Reset   = fsm_reset_q;
    assign ComActive   = com_active_q;
    assign Grant       = grant_q;
    assign WordCount   = wcount_q;
    assign TimeoutFlag = timeout_q;
endmodule

// File: tb/tb_config_source_arbiter.sv
// Directed bench for config_source_arbiter. With CFG_ARB_TIMEOUT_EN defined
// the idle-timeout release is exercised, otherwise ownership must persist.
module tb_config_source_arbiter;
    logic        CLK;
    logic        resetn;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        FSM_Reset;
    logic        ComActive;
    logic [1:0]  Grant;
    logic [15:0] WordCount;
    logic        TimeoutFlag;

    int total;
    int bad;

    config_source_arbiter_if #(.DataWidth(32)) s0_if ();
    config_source_arbiter_if #(.DataWidth(32)) s1_if ();

    config_source_arbiter #(
        .DataWidth    (32),
        .CountWidth   (16),
        .TimeoutCycles(16)
    ) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .src0       (s0_if),
        .src1       (s1_if),
        .WriteData  (WriteData),
        .WriteStrobe(WriteStrobe),
        .FSM_Reset  (FSM_Reset),
        .ComActive  (ComActive),
        .Grant      (Grant),
        .WordCount  (WordCount),
        .TimeoutFlag(TimeoutFlag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        s0_if.data = '0; s0_if.valid = 1'b0; s0_if.active = 1'b0;
        s1_if.data = '0; s1_if.valid = 1'b0; s1_if.active = 1'b0;
        tick();
        tick();
        chk("rst_grant", Grant, 2'b00);
        chk("rst_strobe", WriteStrobe, 1'b0);
        chk("rst_fsmreset", FSM_Reset, 1'b0);
        chk("rst_comactive", ComActive, 1'b0);
        chk("rst_count", WordCount, 16'd0);
        chk("rst_timeout", TimeoutFlag, 1'b0);
        chk("rst_wdata", WriteData, 32'd0);
        resetn = 1'b1;
        tick();
        chk("idle_grant", Grant, 2'b00);

        // Both sources active together: rr pointer starts at src0.
        s0_if.active = 1'b1;
        s1_if.active = 1'b1;
        tick();
        chk("both_grant_first", Grant, 2'b01);
        chk("both_fsmreset", FSM_Reset, 1'b1);
        chk("both_comactive", ComActive, 1'b1);
        tick();
        chk("own_fsmreset_low", FSM_Reset, 1'b0);
        s0_if.active = 1'b0;
        tick();
        chk("rel_grant", Grant, 2'b00);
        chk("rel_comactive", ComActive, 1'b0);
        s0_if.active = 1'b1;
        tick();
        chk("idle_after_rel", Grant, 2'b00);
        tick();
        chk("rr_grant_second", Grant, 2'b10);
        chk("rr_fsmreset", FSM_Reset, 1'b1);
        tick();
        s1_if.active = 1'b0;
        tick();
        tick();
        tick();
        chk("back_to_src0", Grant, 2'b01);
        tick();

        // src1 word while src0 owns must be held off.
        s1_if.active = 1'b1;
        s1_if.valid  = 1'b1;
        s1_if.data   = 32'h1234_5678;
        #1;
        chk("blocked_ready1", s1_if.ready, 1'b0);
        chk("blocked_ready0", s0_if.ready, 1'b0);
        tick();
        chk("blocked_nostrobe", WriteStrobe, 1'b0);
        tick();
        chk("blocked_nostrobe2", WriteStrobe, 1'b0);
        chk("blocked_count", WordCount, 16'd0);
        s0_if.active = 1'b0;
        tick();
        chk("s0_rel_grant", Grant, 2'b00);
        tick();
        tick();
        chk("s1_grant", Grant, 2'b10);
        chk("s1_sync_ready", s1_if.ready, 1'b0);
        tick();
        chk("s1_own_ready", s1_if.ready, 1'b1);
        tick();
        chk("s1_word_strobe", WriteStrobe, 1'b1);
        chk("s1_word_data", WriteData, 32'h1234_5678);
        chk("s1_word_count", WordCount, 16'd1);
        s1_if.valid  = 1'b0;
        s1_if.active = 1'b0;
        tick();
        chk("s1_rel_strobe", WriteStrobe, 1'b0);
        chk("s1_rel_grant", Grant, 2'b00);
        tick();

        // src0 streams four words back to back.
        s0_if.active = 1'b1;
        tick();
        chk("t1_fsmreset", FSM_Reset, 1'b1);
        chk("t1_grant", Grant, 2'b01);
        chk("t1_count_clr", WordCount, 16'd0);
        s0_if.valid = 1'b1;
        s0_if.data  = 32'hA0;
        #1;
        chk("t1_sync_ready", s0_if.ready, 1'b0);
        tick();
        chk("t1_own_ready", s0_if.ready, 1'b1);
        chk("t1_nostrobe_yet", WriteStrobe, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s0_if.data = 32'hA0 + 32'(i);
            tick();
            chk("t1_strobe", WriteStrobe, 1'b1);
            chk("t1_data", WriteData, 32'hA0 + 32'(i));
            chk("t1_count", WordCount, 16'(i + 1));
        end
        s0_if.valid = 1'b0;
        tick();
        chk("t1_idle_strobe", WriteStrobe, 1'b0);
        chk("t1_final_count", WordCount, 16'd4);
        chk("t1_still_owned", Grant, 2'b01);

        // Last word arrives in the same cycle active falls.
        s0_if.valid  = 1'b1;
        s0_if.data   = 32'hDEAD_BEEF;
        s0_if.active = 1'b0;
        tick();
        chk("t4_strobe", WriteStrobe, 1'b1);
        chk("t4_data", WriteData, 32'hDEAD_BEEF);
        chk("t4_count", WordCount, 16'd5);
        chk("t4_grant", Grant, 2'b00);
        chk("t4_comactive", ComActive, 1'b0);
        s0_if.valid = 1'b0;
        tick();
        chk("t4_after_strobe", WriteStrobe, 1'b0);
        tick();

        // Reset in the middle of a session.
        s0_if.active = 1'b1;
        tick();
        tick();
        s0_if.valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s0_if.data = 32'hC0 + 32'(i);
            tick();
        end
        chk("t5_count_pre", WordCount, 16'd3);
        chk("t5_strobe_pre", WriteStrobe, 1'b1);
        resetn = 1'b0;
        #1;
        chk("t5_grant", Grant, 2'b00);
        chk("t5_strobe", WriteStrobe, 1'b0);
        chk("t5_count", WordCount, 16'd0);
        chk("t5_comactive", ComActive, 1'b0);
        chk("t5_wdata", WriteData, 32'd0);
        chk("t5_ready", s0_if.ready, 1'b0);
        tick();
        resetn = 1'b1;
        tick();
        chk("t5_regrant_strobe", WriteStrobe, 1'b0);
        chk("t5_regrant", Grant, 2'b01);
        chk("t5_regrant_fsmreset", FSM_Reset, 1'b1);
        s0_if.valid  = 1'b0;
        s0_if.active = 1'b0;
        tick();
        chk("t5_sync_strobe", WriteStrobe, 1'b0);
        tick();
        tick();
        chk("t5_back_idle", Grant, 2'b00);

        // Owner holds active with no traffic.
        s0_if.active = 1'b1;
        tick();
        tick();
`ifdef CFG_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        chk("t6_no_early_flag", TimeoutFlag, 1'b0);
        chk("t6_no_early_rel", Grant, 2'b01);
        tick();
        chk("t6_flag", TimeoutFlag, 1'b1);
        chk("t6_grant", Grant, 2'b00);
        chk("t6_comactive", ComActive, 1'b0);
        tick();
        chk("t6_flag_pulse", TimeoutFlag, 1'b0);
        tick();
        chk("t6_regrant", Grant, 2'b01);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("t6_no_flag", TimeoutFlag, 1'b0);
        chk("t6_held_grant", Grant, 2'b01);
        chk("t6_held_comactive", ComActive, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
